// File: rtl/pifctl_regbank.sv
// PIF control-register bank: NUM_REGS control regs with write strobes, sticky W1C status + irq, ID readback.
// Latency: writes visible one edge after presentation; readback valid RD_LAT-1 edges after the access edge.
// Backpressure: none; one access per cycle, results return in order, one per cycle.
//
// Ports:
//   xclk, xrst          clock and asynchronous active-high reset
//   PWr, PRWA, PD       write strobe, register address (also readback select), write data
//   PRdSubA             readback sub-address
//   StatusIn            event inputs folded into the sticky status register
//   XO, RdValid         readback data and valid (last pipeline stage)
//   CtlReg, WrStrobe    control register values and one-cycle post-write pulses
//   StatusIrq           registered OR of (status & mask)
module pifctl_regbank #(
    parameter int NUM_REGS = 2,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int SUBA_W   = 4,
    parameter int NUM_SUBS = 16,
    parameter int RD_LAT   = 4,
    parameter logic [ADDR_W-1:0] W_BASE     = ADDR_W'(8'h10),
    parameter logic [ADDR_W-1:0] W_STAT_CLR = ADDR_W'(8'h1E),
    parameter logic [ADDR_W-1:0] W_IRQ_MASK = ADDR_W'(8'h1F),
    parameter logic [ADDR_W-1:0] R_ID       = ADDR_W'(8'h00),
    parameter logic [DATA_W-1:0] ID_VAL     = DATA_W'(8'h50),
    parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL = '0
) (
    input  logic                         xclk,
    input  logic                         xrst,
    input  logic                         PWr,
    input  logic [ADDR_W-1:0]            PRWA,
    input  logic [DATA_W-1:0]            PD,
    input  logic [SUBA_W-1:0]            PRdSubA,
    input  logic [DATA_W-1:0]            StatusIn,
    output logic [DATA_W-1:0]            XO,
    output logic                         RdValid,
    output logic [NUM_REGS*DATA_W-1:0]   CtlReg,
    output logic [NUM_REGS-1:0]          WrStrobe,
    output logic                         StatusIrq
);

    localparam int unsigned L_NSUBS = NUM_SUBS;

    logic [NUM_REGS-1:0][DATA_W-1:0] r_ctl;
    logic [NUM_REGS-1:0]             r_strb;
    logic [DATA_W-1:0]               r_stat;
    logic [DATA_W-1:0]               r_mask;
    logic                            r_irq;
    logic [DATA_W-1:0]               r_pd [RD_LAT];
    logic [RD_LAT-1:0]               r_pv;

    logic [NUM_REGS-1:0] w_hit_ctl;
    logic                w_hit_clr;
    logic                w_hit_mask;
    logic [DATA_W-1:0]   w_clr;
    logic [DATA_W-1:0]   w_stat_nxt;
    logic [DATA_W-1:0]   w_mask_nxt;
    logic                w_rd_hit;
    logic [SUBA_W-1:0]   w_sub;
    logic [SUBA_W+3:0]   w_tag_raw;
    logic [DATA_W-1:0]   w_tag;
    logic [DATA_W-1:0]   w_sel;

    // ---------------- write decode ----------------
    always_comb begin
        w_hit_ctl = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            w_hit_ctl[k] = PWr && (PRWA == W_BASE + ADDR_W'(k));
        end
    end

    assign w_hit_clr  = PWr && (PRWA == W_STAT_CLR);
    assign w_hit_mask = PWr && (PRWA == W_IRQ_MASK);
    assign w_clr      = w_hit_clr ? PD : '0;

    // Clear wins over a same-cycle event; a held event re-sets the bit next edge.
    assign w_stat_nxt = (r_stat | StatusIn) & ~w_clr;
    assign w_mask_nxt = w_hit_mask ? PD : r_mask;

    always_ff @(posedge xclk or posedge xrst) begin
        if (xrst) begin
            r_ctl  <= RST_VAL;
            r_strb <= '0;
            r_stat <= '0;
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_hit_ctl[k]) begin
                    r_ctl[k] <= PD;
                end
            end
            r_strb <= w_hit_ctl;
            r_stat <= w_stat_nxt;
            r_mask <= w_mask_nxt;
            // Uses next-state values so irq tracks status/mask in the same cycle they change.
            r_irq  <= |(w_stat_nxt & w_mask_nxt);
        end
    end

    // ---------------- readback select ----------------
    assign w_rd_hit  = (PRWA == R_ID);
    assign w_sub     = SUBA_W'(32'(PRdSubA) % L_NSUBS);
    // Letter tag is built from the raw sub-address, not the wrapped one.
    assign w_tag_raw = {4'h6, PRdSubA};
    assign w_tag     = DATA_W'(w_tag_raw);

    always_comb begin
        w_sel = w_tag;
        if (w_sub == '0) begin
            w_sel = ID_VAL;
        end
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_sub == SUBA_W'(k + 1)) begin
                w_sel = r_ctl[k];
            end
        end
        if (w_sub == SUBA_W'(NUM_REGS + 1)) begin
            w_sel = r_stat;
        end
        if (w_sub == SUBA_W'(NUM_REGS + 2)) begin
            w_sel = r_mask;
        end
    end

    // ---------------- readback pipeline ----------------
    always_ff @(posedge xclk or posedge xrst) begin
        if (xrst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pd[i] <= '0;
            end
            r_pv <= '0;
        end else begin
            r_pd[0] <= w_rd_hit ? w_sel : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pd[i] <= r_pd[i-1];
            end
            r_pv <= {r_pv[RD_LAT-2:0], w_rd_hit};
        end
    end

    assign XO        = r_pd[RD_LAT-1];
    assign RdValid   = r_pv[RD_LAT-1];
    assign CtlReg    = r_ctl;
    assign WrStrobe  = r_strb;
    assign StatusIrq = r_irq;

endmodule

// File: tb/tb_pifctl_regbank.sv
// Bench for pifctl_regbank: two instances (defaults with a non-zero reset image, and a wide/short-latency variant).
// Latency: each step drives one access, waits one edge, samples 1 time unit later.
// Backpressure: not applicable; a new access every cycle.
module tb_pifctl_regbank;

    logic        xclk;
    logic        xrst;
    logic        PWr;
    logic [7:0]  PRWA;
    logic [3:0]  PRdSubA;
    logic [7:0]  a_pd, a_sin;
    logic [15:0] b_pd, b_sin;

    logic [7:0]  a_xo;
    logic        a_vld;
    logic [15:0] a_ctl;
    logic [1:0]  a_strb;
    logic        a_irq;
    logic [15:0] b_xo;
    logic        b_vld;
    logic [63:0] b_ctl;
    logic [3:0]  b_strb;
    logic        b_irq;

    int checks;
    int errors;

    pifctl_regbank #(.RST_VAL(16'h5AA5)) u_a (
        .xclk(xclk), .xrst(xrst), .PWr(PWr), .PRWA(PRWA), .PD(a_pd), .PRdSubA(PRdSubA),
        .StatusIn(a_sin), .XO(a_xo), .RdValid(a_vld), .CtlReg(a_ctl), .WrStrobe(a_strb),
        .StatusIrq(a_irq)
    );

    pifctl_regbank #(.NUM_REGS(4), .DATA_W(16), .RD_LAT(2)) u_b (
        .xclk(xclk), .xrst(xrst), .PWr(PWr), .PRWA(PRWA), .PD(b_pd), .PRdSubA(PRdSubA),
        .StatusIn(b_sin), .XO(b_xo), .RdValid(b_vld), .CtlReg(b_ctl), .WrStrobe(b_strb),
        .StatusIrq(b_irq)
    );

    initial begin
        xclk = 1'b0;
        forever #5 xclk = ~xclk;
    end

    // ---------------- reference model ----------------
    logic [7:0]  m_a_ctl [2];
    logic [7:0]  m_a_stat, m_a_mask;
    logic [8:0]  q_a [$];
    logic [7:0]  ea_xo;
    logic        ea_vld;
    logic [1:0]  ea_strb;
    logic        ea_irq;

    logic [15:0] m_b_ctl [4];
    logic [15:0] m_b_stat, m_b_mask;
    logic [16:0] q_b [$];
    logic [15:0] eb_xo;
    logic        eb_vld;
    logic [3:0]  eb_strb;
    logic        eb_irq;

    task automatic model_reset();
        m_a_ctl[0] = 8'hA5;
        m_a_ctl[1] = 8'h5A;
        m_a_stat = '0; m_a_mask = '0;
        ea_xo = '0; ea_vld = 1'b0; ea_strb = '0; ea_irq = 1'b0;
        q_a = {};
        repeat (3) q_a.push_back(9'h0);
        for (int k = 0; k < 4; k++) m_b_ctl[k] = '0;
        m_b_stat = '0; m_b_mask = '0;
        eb_xo = '0; eb_vld = 1'b0; eb_strb = '0; eb_irq = 1'b0;
        q_b = {};
        q_b.push_back(17'h0);
    endtask

    function automatic logic [8:0] a_read(input logic [7:0] addr, input logic [3:0] sub);
        logic [7:0] v;
        int s;
        if (addr != 8'h00) return 9'h0;
        s = sub % 16;
        if (s == 0)      v = 8'h50;
        else if (s <= 2) v = m_a_ctl[s-1];
        else if (s == 3) v = m_a_stat;
        else if (s == 4) v = m_a_mask;
        else             v = 8'h60 + 8'(sub);
        return {1'b1, v};
    endfunction

    function automatic logic [16:0] b_read(input logic [7:0] addr, input logic [3:0] sub);
        logic [15:0] v;
        int s;
        if (addr != 8'h00) return 17'h0;
        s = sub % 16;
        if (s == 0)      v = 16'h0050;
        else if (s <= 4) v = m_b_ctl[s-1];
        else if (s == 5) v = m_b_stat;
        else if (s == 6) v = m_b_mask;
        else             v = 16'h0060 + 16'(sub);
        return {1'b1, v};
    endfunction

    // Drives one access, advances one edge, updates the model, then settles 1 unit past the edge.
    task automatic step(input logic pwr, input logic [7:0] addr, input logic [15:0] pd,
                        input logic [3:0] sub, input logic [15:0] sin);
        logic [7:0]  clr_a;
        logic [15:0] clr_b;
        PWr = pwr; PRWA = addr; a_pd = pd[7:0]; b_pd = pd; PRdSubA = sub;
        a_sin = sin[7:0]; b_sin = sin;
        @(posedge xclk);
        q_a.push_back(a_read(addr, sub));
        {ea_vld, ea_xo} = q_a.pop_front();
        q_b.push_back(b_read(addr, sub));
        {eb_vld, eb_xo} = q_b.pop_front();
        ea_strb = '0;
        for (int k = 0; k < 2; k++) begin
            if (pwr && addr == 8'h10 + k) begin
                m_a_ctl[k] = pd[7:0];
                ea_strb[k] = 1'b1;
            end
        end
        eb_strb = '0;
        for (int k = 0; k < 4; k++) begin
            if (pwr && addr == 8'h10 + k) begin
                m_b_ctl[k] = pd;
                eb_strb[k] = 1'b1;
            end
        end
        clr_a = (pwr && addr == 8'h1E) ? pd[7:0] : 8'h0;
        clr_b = (pwr && addr == 8'h1E) ? pd : 16'h0;
        m_a_stat = (m_a_stat | sin[7:0]) & ~clr_a;
        m_b_stat = (m_b_stat | sin) & ~clr_b;
        if (pwr && addr == 8'h1F) begin
            m_a_mask = pd[7:0];
            m_b_mask = pd;
        end
        ea_irq = |(m_a_stat & m_a_mask);
        eb_irq = |(m_b_stat & m_b_mask);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        checks++;
        if (a_ctl !== 16'h5AA5) begin errors++; $display("FAIL reset_ctl_a: got %h exp 5aa5", a_ctl); end
        checks++;
        if ({a_xo, a_vld, a_irq, a_strb} !== 12'h0) begin
            errors++; $display("FAIL reset_out_a: xo=%h vld=%b irq=%b strb=%b exp all 0", a_xo, a_vld, a_irq, a_strb);
        end
        checks++;
        if ({b_ctl, b_xo, b_vld, b_irq, b_strb} !== 86'h0) begin
            errors++; $display("FAIL reset_out_b: ctl=%h xo=%h vld=%b irq=%b exp all 0", b_ctl, b_xo, b_vld, b_irq);
        end
        #2 xrst = 1'b0;
        model_reset();
    endtask

    task automatic test_ctl_write();
        step(1'b1, 8'h11, 16'h003C, 4'd0, 16'h0);
        checks++;
        if (a_strb !== 2'b10 || a_ctl[15:8] !== 8'h3C) begin
            errors++; $display("FAIL ctl_write_a: strb=%b ctl=%h exp strb=10 ctl[15:8]=3c", a_strb, a_ctl);
        end
        checks++;
        if (b_strb !== 4'b0010 || b_ctl[31:16] !== 16'h003C) begin
            errors++; $display("FAIL ctl_write_b: strb=%b ctl=%h exp 0010 / 003c", b_strb, b_ctl);
        end
        for (int j = 0; j < 6; j++) begin
            if (j == 0) step(1'b0, 8'h00, 16'h0, 4'd2, 16'h0);
            else        step(1'b0, 8'h40, 16'h0, 4'd0, 16'h0);
            checks++;
            if (a_strb !== 2'b00) begin errors++; $display("FAIL strobe_width_a: j=%0d got %b exp 00", j, a_strb); end
            checks++;
            if (a_vld !== (j == 3) || (j == 3 && a_xo !== 8'h3C)) begin
                errors++; $display("FAIL readback_lat_a: j=%0d vld=%b xo=%h exp vld=%b xo=3c", j, a_vld, a_xo, j == 3);
            end
            checks++;
            if (b_vld !== (j == 1) || (j == 1 && b_xo !== 16'h003C)) begin
                errors++; $display("FAIL readback_lat_b: j=%0d vld=%b xo=%h exp vld=%b xo=003c", j, b_vld, b_xo, j == 1);
            end
        end
        // Continuous writes keep the strobe asserted.
        for (int j = 0; j < 3; j++) begin
            step(1'b1, 8'h10, 16'(8'h70 + j), 4'd0, 16'h0);
            checks++;
            if (a_strb !== 2'b01 || a_ctl[7:0] !== 8'(8'h70 + j)) begin
                errors++; $display("FAIL b2b_write_a: j=%0d strb=%b ctl=%h", j, a_strb, a_ctl);
            end
        end
    endtask

    task automatic test_sweep();
        logic [7:0]  exp_a [16];
        logic [15:0] exp_b [16];
        for (int s = 0; s < 16; s++) begin
            if (s == 0)      exp_a[s] = 8'h50;
            else if (s <= 2) exp_a[s] = m_a_ctl[s-1];
            else if (s == 3) exp_a[s] = m_a_stat;
            else if (s == 4) exp_a[s] = m_a_mask;
            else             exp_a[s] = 8'(8'h60 + s);
            if (s == 0)      exp_b[s] = 16'h0050;
            else if (s <= 4) exp_b[s] = m_b_ctl[s-1];
            else if (s == 5) exp_b[s] = m_b_stat;
            else if (s == 6) exp_b[s] = m_b_mask;
            else             exp_b[s] = 16'(16'h0060 + s);
        end
        for (int t = 0; t < 19; t++) begin
            if (t < 16) step(1'b0, 8'h00, 16'h0, 4'(t), 16'h0);
            else        step(1'b0, 8'h40, 16'h0, 4'd0, 16'h0);
            checks++;
            if (t >= 3) begin
                if (a_vld !== 1'b1 || a_xo !== exp_a[t-3]) begin
                    errors++; $display("FAIL sweep_a: sub=%0d vld=%b xo=%h exp 1/%h", t - 3, a_vld, a_xo, exp_a[t-3]);
                end
            end else if (a_vld !== 1'b0) begin
                errors++; $display("FAIL sweep_a_early: t=%0d vld=%b exp 0", t, a_vld);
            end
            checks++;
            if (t >= 1 && t <= 16) begin
                if (b_vld !== 1'b1 || b_xo !== exp_b[t-1]) begin
                    errors++; $display("FAIL sweep_b: sub=%0d vld=%b xo=%h exp 1/%h", t - 1, b_vld, b_xo, exp_b[t-1]);
                end
            end else if (b_vld !== 1'b0) begin
                errors++; $display("FAIL sweep_b_edge: t=%0d vld=%b exp 0", t, b_vld);
            end
            if (t == 9) begin
                checks++;
                if (b_xo !== 16'h0068) begin errors++; $display("FAIL tag_b_sub8: got %h exp 0068", b_xo); end
            end
        end
    endtask

    task automatic test_status();
        step(1'b1, 8'h1F, 16'h0004, 4'd0, 16'h0);
        step(1'b0, 8'h40, 16'h0, 4'd0, 16'h0004);
        step(1'b0, 8'h40, 16'h0, 4'd0, 16'h0020);
        checks++;
        if (a_irq !== 1'b1 || b_irq !== 1'b1) begin
            errors++; $display("FAIL irq_set: a=%b b=%b exp 1/1", a_irq, b_irq);
        end
        step(1'b0, 8'h00, 16'h0, 4'd3, 16'h0);
        for (int j = 1; j <= 3; j++) step(1'b0, 8'h40, 16'h0, 4'd0, 16'h0);
        checks++;
        if (a_vld !== 1'b1 || a_xo !== 8'h24) begin
            errors++; $display("FAIL status_read_24: vld=%b xo=%h exp 1/24", a_vld, a_xo);
        end
        step(1'b1, 8'h1E, 16'h0004, 4'd0, 16'h0);
        checks++;
        if (a_irq !== 1'b0 || b_irq !== 1'b0) begin
            errors++; $display("FAIL irq_clear: a=%b b=%b exp 0/0", a_irq, b_irq);
        end
        step(1'b0, 8'h00, 16'h0, 4'd3, 16'h0);
        for (int j = 1; j <= 3; j++) step(1'b0, 8'h40, 16'h0, 4'd0, 16'h0);
        checks++;
        if (a_vld !== 1'b1 || a_xo !== 8'h20) begin
            errors++; $display("FAIL status_read_20: vld=%b xo=%h exp 1/20", a_vld, a_xo);
        end
        step(1'b1, 8'h1F, 16'h0020, 4'd0, 16'h0);
        checks++;
        if (a_irq !== 1'b1) begin errors++; $display("FAIL irq_mask5: got %b exp 1", a_irq); end
        // Clear with the event held: cleared on this edge, re-set on the next.
        step(1'b1, 8'h1E, 16'h0020, 4'd0, 16'h0020);
        checks++;
        if (a_irq !== 1'b0) begin errors++; $display("FAIL clr_wins: got %b exp 0", a_irq); end
        step(1'b0, 8'h40, 16'h0, 4'd0, 16'h0020);
        checks++;
        if (a_irq !== 1'b1 || b_irq !== 1'b1) begin
            errors++; $display("FAIL held_event_resets: a=%b b=%b exp 1/1", a_irq, b_irq);
        end
        // Clear with the event present for only that cycle: event is lost.
        step(1'b1, 8'h1E, 16'h0020, 4'd0, 16'h0020);
        step(1'b0, 8'h40, 16'h0, 4'd0, 16'h0);
        checks++;
        if (a_irq !== 1'b0) begin errors++; $display("FAIL event_lost: got %b exp 0", a_irq); end
    endtask

    task automatic test_unmatched();
        step(1'b0, 8'h01, 16'h0, 4'd0, 16'h0);
        for (int j = 1; j <= 3; j++) begin
            step(1'b0, 8'h40, 16'h0, 4'd0, 16'h0);
            checks++;
            if (a_vld !== 1'b0 || a_xo !== 8'h0 || b_vld !== 1'b0 || b_xo !== 16'h0) begin
                errors++; $display("FAIL unmatched_read: j=%0d a=%b/%h b=%b/%h exp 0", j, a_vld, a_xo, b_vld, b_xo);
            end
        end
        step(1'b1, 8'h1D, 16'($urandom), 4'd0, 16'h0);
        checks++;
        if (a_strb !== 2'b00 || b_strb !== 4'b0000 || a_ctl !== {m_a_ctl[1], m_a_ctl[0]}
            || b_ctl !== {m_b_ctl[3], m_b_ctl[2], m_b_ctl[1], m_b_ctl[0]} || a_irq !== ea_irq) begin
            errors++; $display("FAIL unmatched_write: strb=%b/%b ctl=%h/%h irq=%b", a_strb, b_strb, a_ctl, b_ctl, a_irq);
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 8'h1F, 16'hFFFF, 4'd0, 16'h0);
        step(1'b0, 8'h00, 16'h0, 4'd3, 16'h0101);
        step(1'b0, 8'h00, 16'h0, 4'd0, 16'h0);
        checks++;
        if (a_irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b exp 1", a_irq); end
        #3 xrst = 1'b1;
        #1;
        checks++;
        if (a_ctl !== 16'h5AA5 || a_xo !== 8'h0 || a_vld !== 1'b0 || a_irq !== 1'b0 || a_strb !== 2'b00) begin
            errors++; $display("FAIL midreset_a: ctl=%h xo=%h vld=%b irq=%b exp 5aa5/0/0/0", a_ctl, a_xo, a_vld, a_irq);
        end
        checks++;
        if (b_ctl !== 64'h0 || b_vld !== 1'b0 || b_irq !== 1'b0) begin
            errors++; $display("FAIL midreset_b: ctl=%h vld=%b irq=%b exp 0", b_ctl, b_vld, b_irq);
        end
        #2 xrst = 1'b0;
        model_reset();
        step(1'b1, 8'h10, 16'h1234, 4'd0, 16'h0);
        checks++;
        if (a_ctl !== 16'h5A34 || a_strb !== 2'b01 || b_ctl[15:0] !== 16'h1234) begin
            errors++; $display("FAIL first_write_after_reset: a=%h strb=%b b=%h exp 5a34/01/1234", a_ctl, a_strb, b_ctl[15:0]);
        end
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 8'h40, 16'h0, 4'd0, 16'h0);
            checks++;
            if (a_vld !== 1'b0 || b_vld !== 1'b0) begin
                errors++; $display("FAIL stale_valid: j=%0d a=%b b=%b exp 0", j, a_vld, b_vld);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] addrs [8];
        logic [7:0] addr;
        logic [15:0] sin;
        addrs = '{8'h00, 8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h1E, 8'h1F};
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) addr = 8'($urandom);
            else addr = addrs[$urandom_range(0, 7)];
            sin = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
            step(1'($urandom_range(0, 1)), addr, 16'($urandom), 4'($urandom), sin);
            checks++;
            if ({a_vld, a_xo, a_ctl, a_strb, a_irq} !== {ea_vld, ea_xo, m_a_ctl[1], m_a_ctl[0], ea_strb, ea_irq}) begin
                errors++;
                $display("FAIL random_a: n=%0d got vld=%b xo=%h ctl=%h strb=%b irq=%b exp %b %h %h%h %b %b", n,
                         a_vld, a_xo, a_ctl, a_strb, a_irq, ea_vld, ea_xo, m_a_ctl[1], m_a_ctl[0], ea_strb, ea_irq);
            end
            checks++;
            if ({b_vld, b_xo, b_ctl, b_strb, b_irq} !==
                {eb_vld, eb_xo, m_b_ctl[3], m_b_ctl[2], m_b_ctl[1], m_b_ctl[0], eb_strb, eb_irq}) begin
                errors++;
                $display("FAIL random_b: n=%0d got vld=%b xo=%h ctl=%h strb=%b irq=%b exp vld=%b xo=%h strb=%b irq=%b",
                         n, b_vld, b_xo, b_ctl, b_strb, b_irq, eb_vld, eb_xo, eb_strb, eb_irq);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        xrst = 1'b1;
        PWr = 1'b0; PRWA = 8'h40; PRdSubA = '0;
        a_pd = '0; a_sin = '0; b_pd = '0; b_sin = '0;
        model_reset();
        test_reset();
        test_ctl_write();
        test_sweep();
        test_status();
        test_unmatched();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
